// File: rtl/gemm_tile_scheduler_pkg.sv
// Shared types and helpers for the GeMM tile scheduler.
// Latency: none (types, constants, combinational helper only).
// Backpressure: not applicable.
package gemm_pkg;

  localparam int unsigned DefaultLanes = 4;
  localparam int unsigned MaxSizeWidth = 32;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StIssue   = 3'd1,
    StWait    = 3'd2,
    StAdvance = 3'd3,
    StFinish  = 3'd4,
    StError   = 3'd5
  } sched_state_e;

  // Number of P-wide tiles along one dimension; P is a power of 2, so a shift suffices.
  function automatic logic [MaxSizeWidth-1:0] tile_count(input logic [MaxSizeWidth-1:0] size,
                                                        input int unsigned lanes_log2);
    return size >> lanes_log2;
  endfunction

endpackage

// File: rtl/gemm_tile_scheduler_if.sv
// Host/core signal bundle of the GeMM tile scheduler.
// Latency: wires only.
// Backpressure: none; the core gates progress through its done pulse.
interface gemm_tile_scheduler_if #(
  parameter int unsigned AddrWidth     = 16,
  parameter int unsigned SizeAddrWidth = 8
);
  logic                     start_i;
  logic [SizeAddrWidth-1:0] M_size_i;
  logic [SizeAddrWidth-1:0] K_size_i;
  logic [SizeAddrWidth-1:0] N_size_i;
  logic                     core_start_o;
  logic                     core_done_i;
  logic [AddrWidth-1:0]     a_base_o;
  logic [AddrWidth-1:0]     b_base_o;
  logic [AddrWidth-1:0]     c_base_o;
  logic [SizeAddrWidth-1:0] m_tile_o;
  logic [SizeAddrWidth-1:0] n_tile_o;
  logic                     busy_o;
  logic                     done_o;
  logic                     err_o;

  // Scheduler side.
  modport slave (
    input  start_i, M_size_i, K_size_i, N_size_i, core_done_i,
    output core_start_o, a_base_o, b_base_o, c_base_o, m_tile_o, n_tile_o,
           busy_o, done_o, err_o
  );

  // Host plus core side.
  modport master (
    output start_i, M_size_i, K_size_i, N_size_i, core_done_i,
    input  core_start_o, a_base_o, b_base_o, c_base_o, m_tile_o, n_tile_o,
           busy_o, done_o, err_o
  );
endinterface

// File: rtl/gemm_tile_scheduler_ceiling_counter.sv
// Wrapping counter 0..ceiling-1 with a last-value flag.
// Latency: count updates on the clock edge after tick_i.
// Backpressure: none; holds whenever tick_i is low.
module ceiling_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic [Width-1:0] ceiling_i,
  output logic [Width-1:0] count_o,
  output logic             last_value_o
);
  logic [Width-1:0] r_count;

  assign last_value_o = (r_count == (ceiling_i - Width'(1)));
  assign count_o      = r_count;

  // Clear wins over tick; wrap to zero after the last value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (tick_i) begin
      r_count <= last_value_o ? '0 : (r_count + Width'(1));
    end
  end
endmodule

// File: rtl/gemm_tile_scheduler.sv
// Walks C in PxP tiles (n inner, m outer), issuing one core start per tile with its A/B/C bases.
// Latency: core_start 1 cycle after accepted start; next start or done 2 cycles after core_done.
// Backpressure: waits indefinitely for core_done; start is ignored while busy.
module gemm_tile_scheduler
  import gemm_pkg::*;
#(
  parameter int unsigned AddrWidth        = 16,
  parameter int unsigned SizeAddrWidth    = 8,
  parameter int unsigned NumParallelLanes = DefaultLanes
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  gemm_tile_scheduler_if.slave bus
);
  localparam int unsigned LanesLog2 = $clog2(NumParallelLanes);

  sched_state_e             r_state;
  sched_state_e             w_state_d;
  logic [SizeAddrWidth-1:0] r_m_size;
  logic [SizeAddrWidth-1:0] r_k_size;
  logic [SizeAddrWidth-1:0] r_n_size;
  logic [AddrWidth-1:0]     r_a_base;
  logic [AddrWidth-1:0]     r_b_base;
  logic [AddrWidth-1:0]     r_c_row;
  logic [SizeAddrWidth-1:0] w_m_tiles;
  logic [SizeAddrWidth-1:0] w_n_tiles;
  logic [SizeAddrWidth-1:0] w_m_tile;
  logic [SizeAddrWidth-1:0] w_n_tile;
  logic [AddrWidth-1:0]     w_a_step;
  logic [AddrWidth-1:0]     w_c_step;
  logic                     w_sizes_ok;
  logic                     w_accept;
  logic                     w_step;
  logic                     w_n_last;
  logic                     w_m_last;
  logic                     w_last_tile;

  function automatic logic size_ok(input logic [SizeAddrWidth-1:0] size);
    return (size != '0) && (size[LanesLog2-1:0] == '0);
  endfunction

  assign w_sizes_ok  = size_ok(bus.M_size_i) && size_ok(bus.K_size_i) && size_ok(bus.N_size_i);
  assign w_accept    = (r_state == StIdle) && bus.start_i && w_sizes_ok;
  assign w_last_tile = w_m_last && w_n_last;
  // The final Advance does not step, so bases and indices keep the last tile's values.
  assign w_step      = (r_state == StAdvance) && !w_last_tile;

  assign w_m_tiles = SizeAddrWidth'(tile_count(MaxSizeWidth'(r_m_size), LanesLog2));
  assign w_n_tiles = SizeAddrWidth'(tile_count(MaxSizeWidth'(r_n_size), LanesLog2));
  // One tile row down moves A by P*K and C by P*N.
  assign w_a_step  = AddrWidth'(r_k_size) << LanesLog2;
  assign w_c_step  = AddrWidth'(r_n_size) << LanesLog2;

  ceiling_counter #(.Width(SizeAddrWidth)) u_n_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (w_accept),
    .tick_i      (w_step),
    .ceiling_i   (w_n_tiles),
    .count_o     (w_n_tile),
    .last_value_o(w_n_last)
  );

  ceiling_counter #(.Width(SizeAddrWidth)) u_m_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (w_accept),
    .tick_i      (w_step && w_n_last),
    .ceiling_i   (w_m_tiles),
    .count_o     (w_m_tile),
    .last_value_o(w_m_last)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  // Next-state logic; core_done is only looked at in Wait.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:    if (bus.start_i) w_state_d = w_sizes_ok ? StIssue : StError;
      StIssue:   w_state_d = StWait;
      StWait:    if (bus.core_done_i) w_state_d = StAdvance;
      StAdvance: w_state_d = w_last_tile ? StFinish : StIssue;
      StFinish:  w_state_d = StIdle;
      StError:   w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  // Size latch and running base accumulators (no multipliers).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_m_size <= '0;
      r_k_size <= '0;
      r_n_size <= '0;
      r_a_base <= '0;
      r_b_base <= '0;
      r_c_row  <= '0;
    end else if (w_accept) begin
      r_m_size <= bus.M_size_i;
      r_k_size <= bus.K_size_i;
      r_n_size <= bus.N_size_i;
      r_a_base <= '0;
      r_b_base <= '0;
      r_c_row  <= '0;
    end else if (w_step) begin
      if (w_n_last) begin
        r_b_base <= '0;
        r_a_base <= r_a_base + w_a_step;
        r_c_row  <= r_c_row + w_c_step;
      end else begin
        r_b_base <= r_b_base + AddrWidth'(NumParallelLanes);
      end
    end
  end

  assign bus.core_start_o = (r_state == StIssue);
  assign bus.busy_o       = (r_state != StIdle);
  assign bus.done_o       = (r_state == StFinish) || (r_state == StError);
  assign bus.err_o        = (r_state == StError);
  assign bus.a_base_o     = r_a_base;
  assign bus.b_base_o     = r_b_base;
  assign bus.c_base_o     = r_c_row + r_b_base;
  assign bus.m_tile_o     = w_m_tile;
  assign bus.n_tile_o     = w_n_tile;

endmodule
